// File: rtl/rst_seq_gen.sv
// rst_seq_gen -- lock-qualified, staged reset release sequencer.
//
// Waits until every clock-lock indicator has been stable high for a hold
// window, then releases the active-low downstream resets one channel at a
// time, lowest index first, with a fixed gap between releases. Any lock
// loss (counted) or software request (not counted) drops every channel
// together and restarts the sequence from IDLE.
//
// Ports
//   sysclk        : single clock, all state on its rising edge
//   sysrst        : asynchronous active-high reset
//   lock_in       : asynchronous lock indicators, all must be high
//   sw_rst_req    : synchronous single-cycle request to re-run the sequence
//   arstn         : active-low reset per downstream domain, bit 0 first
//   done          : high once every channel is released
//   state         : FSM state (IDLE=0, HOLD=1, RELEASE=2, RUN=3)
//   lock_loss_cnt : saturating count of lock-loss events
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | all channels held in reset, waiting for lock_ok
// HOLD    | lock_ok seen, counting the hold window before first release
// RELEASE | releasing remaining channels, one per C_STAGE_GAP cycles
// RUN     | all channels released, done high

module rst_seq_gen #(
   parameter int C_NUM_RST     = 3,
   parameter int C_LOCK_WIDTH  = 2,
   parameter int C_SYNC_STAGES = 2,
   parameter int C_HOLD_CYCLES = 16,
   parameter int C_STAGE_GAP   = 4
) (
   input  logic                    sysclk,
   input  logic                    sysrst,
   input  logic [C_LOCK_WIDTH-1:0] lock_in,
   input  logic                    sw_rst_req,
   output logic [C_NUM_RST-1:0]    arstn,
   output logic                    done,
   output logic [1:0]              state,
   output logic [7:0]              lock_loss_cnt
);

   localparam int HW = (C_HOLD_CYCLES > 1) ? $clog2(C_HOLD_CYCLES) : 1;
   localparam int GW = (C_STAGE_GAP   > 1) ? $clog2(C_STAGE_GAP)   : 1;
   localparam int CW = (C_NUM_RST     > 1) ? $clog2(C_NUM_RST)     : 1;

   localparam logic [HW-1:0] LP_HOLD_TC = HW'(C_HOLD_CYCLES - 1);
   localparam logic [GW-1:0] LP_GAP_TC  = GW'(C_STAGE_GAP - 1);
   localparam logic [CW-1:0] LP_LAST_CH = CW'(C_NUM_RST - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

   logic [C_LOCK_WIDTH-1:0] r_sync [C_SYNC_STAGES];
   logic                    w_lock_ok;

   state_t                  r_state;
   logic [C_NUM_RST-1:0]    r_arstn;
   logic                    r_done;
   logic [7:0]              r_lock_loss_cnt;
   logic [HW-1:0]           r_hold_cnt;
   logic [GW-1:0]           r_gap_cnt;
   logic [CW-1:0]           r_ch_idx;   // next channel to release

   always_ff @(posedge sysclk or posedge sysrst) begin
      if (sysrst) begin
         for (int i = 0; i < C_SYNC_STAGES; i++) begin
            r_sync[i] <= '0;
         end
      end else begin
         r_sync[0] <= lock_in;
         for (int i = 1; i < C_SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign w_lock_ok = &r_sync[C_SYNC_STAGES-1];

   always_ff @(posedge sysclk or posedge sysrst) begin
      if (sysrst) begin
         r_state         <= ST_IDLE;
         r_arstn         <= '0;
         r_done          <= 1'b0;
         r_lock_loss_cnt <= '0;
         r_hold_cnt      <= '0;
         r_gap_cnt       <= '0;
         r_ch_idx        <= '0;
      end else if (r_state == ST_IDLE) begin
         // sw_rst_req is deliberately ignored here: nothing is released yet
         if (w_lock_ok) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
         end
      end else if (!w_lock_ok || sw_rst_req) begin
         // Abort: all channels back into reset together. A lock loss wins
         // over a coincident software request, so it is still counted.
         r_state    <= ST_IDLE;
         r_arstn    <= '0;
         r_done     <= 1'b0;
         r_hold_cnt <= '0;
         r_gap_cnt  <= '0;
         r_ch_idx   <= '0;
         if (!w_lock_ok && (r_lock_loss_cnt != 8'hFF)) begin
            r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
         end
      end else begin
         case (r_state)
            ST_HOLD: begin
               if (r_hold_cnt == LP_HOLD_TC) begin
                  r_arstn[0] <= 1'b1;
                  r_hold_cnt <= '0;
                  if (C_NUM_RST == 1) begin
                     r_done  <= 1'b1;
                     r_state <= ST_RUN;
                  end else begin
                     r_state   <= ST_RELEASE;
                     r_gap_cnt <= '0;
                     r_ch_idx  <= CW'(1);
                  end
               end else begin
                  r_hold_cnt <= r_hold_cnt + HW'(1);
               end
            end
            ST_RELEASE: begin
               if (r_gap_cnt == LP_GAP_TC) begin
                  r_gap_cnt          <= '0;
                  r_arstn[r_ch_idx]  <= 1'b1;
                  if (r_ch_idx == LP_LAST_CH) begin
                     r_done  <= 1'b1;
                     r_state <= ST_RUN;
                  end else begin
                     r_ch_idx <= r_ch_idx + CW'(1);
                  end
               end else begin
                  r_gap_cnt <= r_gap_cnt + GW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign arstn         = r_arstn;
   assign done          = r_done;
   assign state         = r_state;
   assign lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Testbench for rst_seq_gen at default parameters. Stimulus pushes the
// expected output changes (value plus the clock edge they must land on)
// into a queue; a monitor pops one entry each time the DUT outputs change.
module tb_rst_seq_gen;

   logic       sysclk = 1'b0;
   logic       sysrst;
   logic [1:0] lock_in;
   logic       sw_rst_req;
   logic [2:0] arstn;
   logic       done;
   logic [1:0] state;
   logic [7:0] lock_loss_cnt;

   rst_seq_gen dut (
      .sysclk        (sysclk),
      .sysrst        (sysrst),
      .lock_in       (lock_in),
      .sw_rst_req    (sw_rst_req),
      .arstn         (arstn),
      .done          (done),
      .state         (state),
      .lock_loss_cnt (lock_loss_cnt)
   );

   always #5 sysclk = ~sysclk;

   int cyc = 0;
   always @(posedge sysclk) cyc <= cyc + 1;

   typedef struct {
      string      nm;
      logic [2:0] a;
      logic       d;
      logic [1:0] s;
      logic [7:0] l;
      int         c;     // expected edge number, -1 when not timed
   } ev_t;

   ev_t q[$];
   int  n_chk  = 0;
   int  n_pass = 0;
   bit  mon_en = 0;
   int  exp_llc = 0;

   task automatic push(string nm, logic [2:0] a, logic d, logic [1:0] s, int c);
      ev_t e;
      e.nm = nm; e.a = a; e.d = d; e.s = s; e.l = 8'(exp_llc); e.c = c;
      q.push_back(e);
   endtask

   task automatic check(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic at_cyc(int c);
      while (cyc < c) @(negedge sysclk);
   endtask

   // monitor
   initial begin
      logic [13:0] prev, cur;
      ev_t e;
      wait (mon_en);
      prev = {arstn, done, state, lock_loss_cnt};
      forever begin
         @(negedge sysclk or posedge sysrst);
         #1;
         cur = {arstn, done, state, lock_loss_cnt};
         if (cur !== prev) begin
            if (q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_change @edge %0d: arstn=%b done=%b state=%0d llc=%0d", cyc, arstn, done, state, lock_loss_cnt);
            end else begin
               e = q.pop_front();
               n_chk++;
               if (cur === {e.a, e.d, e.s, e.l}) n_pass++;
               else $display("FAIL %s value: got arstn=%b done=%b state=%0d llc=%0d expected arstn=%b done=%b state=%0d llc=%0d",
                             e.nm, arstn, done, state, lock_loss_cnt, e.a, e.d, e.s, e.l);
               if (e.c >= 0) check({e.nm, "_edge"}, cyc, e.c);
            end
            prev = cur;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int d, h, r;
      sysrst = 1'b1; lock_in = 2'b00; sw_rst_req = 1'b0;
      repeat (3) @(negedge sysclk);
      check("rst_arstn", int'(arstn), 0);
      check("rst_done", int'(done), 0);
      check("rst_state", int'(state), 0);
      check("rst_llc", int'(lock_loss_cnt), 0);
      sysrst = 1'b0;
      mon_en = 1;
      repeat (2) @(negedge sysclk);

      // both locks rise together
      d = cyc; lock_in = 2'b11;
      push("t1_hold", 3'b000, 0, 1, d + 3);
      push("t1_rel0", 3'b001, 0, 2, d + 19);
      push("t1_rel1", 3'b011, 0, 2, d + 23);
      push("t1_run",  3'b111, 1, 3, d + 27);
      at_cyc(d + 30);

      // lock_in[1] low for three cycles during RUN
      d = cyc; lock_in = 2'b01; exp_llc = 1;
      push("t2_loss", 3'b000, 0, 0, d + 3);
      push("t2_hold", 3'b000, 0, 1, d + 6);
      push("t2_rel0", 3'b001, 0, 2, d + 22);
      push("t2_rel1", 3'b011, 0, 2, d + 26);
      push("t2_run",  3'b111, 1, 3, d + 30);
      at_cyc(d + 3); lock_in = 2'b11;
      at_cyc(d + 33);

      // software reset request in RUN
      d = cyc; sw_rst_req = 1'b1;
      push("t3_swrst", 3'b000, 0, 0, d + 1);
      push("t3_hold",  3'b000, 0, 1, d + 2);
      push("t3_rel0",  3'b001, 0, 2, d + 18);
      push("t3_rel1",  3'b011, 0, 2, d + 22);
      push("t3_run",   3'b111, 1, 3, d + 26);
      at_cyc(d + 1); sw_rst_req = 1'b0;
      at_cyc(d + 30);

      // one-cycle lock glitch reaching the FSM at hold count 10
      d = cyc; sw_rst_req = 1'b1; h = d + 2;
      push("t4_swrst", 3'b000, 0, 0, d + 1);
      push("t4_hold",  3'b000, 0, 1, h);
      at_cyc(d + 1); sw_rst_req = 1'b0;
      at_cyc(h + 8); lock_in = 2'b00; exp_llc = 2;
      push("t4_glitch", 3'b000, 0, 0, h + 11);
      push("t4_hold2",  3'b000, 0, 1, h + 12);
      push("t4_rel0",   3'b001, 0, 2, h + 28);
      push("t4_rel1",   3'b011, 0, 2, h + 32);
      push("t4_run",    3'b111, 1, 3, h + 36);
      at_cyc(h + 9); lock_in = 2'b11;
      at_cyc(h + 40);

      // lock loss and sw_rst_req on the same cycle: counted as lock loss
      d = cyc; lock_in = 2'b00; exp_llc = 3;
      push("t5_both", 3'b000, 0, 0, d + 3);
      at_cyc(d + 2); sw_rst_req = 1'b1;
      at_cyc(d + 3); sw_rst_req = 1'b0;
      // sw_rst_req in IDLE must produce no output change
      at_cyc(d + 5); sw_rst_req = 1'b1;
      at_cyc(d + 6); sw_rst_req = 1'b0;
      at_cyc(d + 9);

      // 300 lock losses from HOLD: counter saturates at 255
      for (int i = 0; i < 300; i++) begin
         d = cyc; lock_in = 2'b11;
         push("t6_hold", 3'b000, 0, 1, d + 3);
         at_cyc(d + 3); lock_in = 2'b00;
         if (exp_llc < 255) exp_llc++;
         push("t6_loss", 3'b000, 0, 0, d + 6);
         at_cyc(d + 6);
      end
      check("sat_llc", int'(lock_loss_cnt), 255);

      // sysrst while arstn=011 acts without a clock edge
      d = cyc; lock_in = 2'b11;
      push("t7_hold", 3'b000, 0, 1, d + 3);
      push("t7_rel0", 3'b001, 0, 2, d + 19);
      push("t7_rel1", 3'b011, 0, 2, d + 23);
      at_cyc(d + 24);
      exp_llc = 0;
      push("t7_async", 3'b000, 0, 0, -1);
      #2 sysrst = 1'b1;
      #1;
      check("async_arstn", int'(arstn), 0);
      check("async_state", int'(state), 0);
      check("async_llc", int'(lock_loss_cnt), 0);
      @(negedge sysclk);
      r = cyc; sysrst = 1'b0;
      push("t7_hold2", 3'b000, 0, 1, r + 3);
      push("t7_rel0b", 3'b001, 0, 2, r + 19);
      push("t7_rel1b", 3'b011, 0, 2, r + 23);
      push("t7_run",   3'b111, 1, 3, r + 27);
      at_cyc(r + 32);

      check("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
